alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational 32-bit ALU between two requesters (r0, r1).
//  Round-robin grant, registered issue, registered result, per-port
//  valid/ready on both request and response. Sits between the pipeline
//  front-ends and the ALU instance; the ALU itself stays opcode-owner.
// PARAMETERS
//  DATA_W      32  operand/result width
//  OP_W        3   ALU control width (opcodes passed through, never decoded)
//  RESET_PRIO  0   requester that wins the first tie after reset (0 or 1)
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  r0_valid      in   1       r0 request valid
//  r0_ready      out  1       r0 request accepted when valid&ready
//  r0_op         in   OP_W    r0 ALU control
//  r0_a, r0_b    in   DATA_W  r0 operands (a -> ALU in1, b -> ALU in2)
//  r1_valid/r1_ready/r1_op/r1_a/r1_b   same as r0 for requester 1
//  r0_rsp_valid  out  1       result for r0 available
//  r0_rsp_ready  in   1       r0 consumes result
//  r1_rsp_valid  out  1       result for r1 available
//  r1_rsp_ready  in   1       r1 consumes result
//  rsp_data      out  DATA_W  result (shared by both response ports)
//  rsp_zero      out  1       1 when rsp_data == 0 (computed here, not by ALU)
//  alu_in1       out  DATA_W  to ALU operand 1
//  alu_in2       out  DATA_W  to ALU operand 2
//  alu_ctrl      out  OP_W    to ALU control
//  alu_out       in   DATA_W  from ALU result
// BEHAVIOUR
//  Reset: state IDLE; r*_ready, r*_rsp_valid, rsp_data, rsp_zero, alu_in1,
//   alu_in2, alu_ctrl all 0; rr pointer set so RESET_PRIO wins first tie.
//  FSM IDLE -> EXEC -> RESP -> IDLE; one transaction in flight, no queue.
//  IDLE: r0_ready = r1_ready = 1 (registered, high only in IDLE).
//   Neither valid: stay. One valid: grant it. Both: grant the requester
//   NOT granted last; pointer updates only on grant. Grant = accept:
//   op/a/b of winner latched into alu_ctrl/alu_in1/alu_in2, owner id
//   latched, -> EXEC. Loser is not accepted and must hold its request.
//  EXEC (1 cycle): ALU settles on registered inputs; at cycle end capture
//   alu_out into rsp_data, rsp_zero = (alu_out == 0), -> RESP.
//  RESP: owner's rsp_valid = 1, other rsp_valid = 0; rsp_data/rsp_zero
//   stable until owner rsp_ready = 1, then rsp_valid drops and -> IDLE.
//   Non-owner rsp_ready is ignored. Both r*_ready = 0 in EXEC and RESP.
//  Latency: accept in cycle N -> rsp_valid in cycle N+2. Max throughput
//   one op per 3 cycles (rsp_ready tied high).
//  alu_in1/alu_in2/alu_ctrl change only on accept; held otherwise.
//  rsp_data/rsp_zero retain last result after consumption.
//  Opcodes 3'b100 and 3'b111 forwarded unchanged; no illegal-op handling.
//  Requester inputs sampled only on accept; changes while not ready ignored.
//  rst_n low in any state: immediate return to reset values; in-flight op
//   dropped, no response ever issued for it.
// STRUCTURE
//  Shared package alu_pkg: ALU_ADD=000, ALU_SUB=001, ALU_AND=010,
//   ALU_OR=011, ALU_SLT=101, ALU_XOR=110; FSM state encodings
//   ST_IDLE/ST_EXEC/ST_RESP (2-bit).
//  Sub-module rr_arb2: 2-way round-robin picker (valid[1:0], pointer ->
//   one-hot grant); FSM, operand/result registers in this module.
//  ALU instantiated alongside by the parent, not inside this block.
// TESTING (bench instantiates this block + ALU)
//  r0 ADD a=5 b=7 alone -> r0_rsp_valid at accept+2, rsp_data=12, zero=0.
//  r0 SUB 9,9 and r1 OR 0xF0,0x0F both valid after reset -> r0 first
//   (data 0, zero=1), then r1 (data 0xFF, zero=0); r1_ready low till IDLE.
//  Both valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1.
//  r0 result with r0_rsp_ready low 4 cycles, r1 asserts r1_rsp_ready ->
//   rsp_data stable, r1_rsp_valid 0, both ready 0; release -> IDLE next.
//  r1 SLT a=0xFFFFFFFF b=1 -> rsp_data=1; r1 XOR equal operands -> zero=1.
//  rst_n low during EXEC -> all outputs 0 asynchronously; after release
//   IDLE, ready=1, no rsp_valid for dropped op; tie goes to RESET_PRIO.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes and arbiter FSM state encodings shared by the ALU sharing logic.
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  assign gnt_o = (&valid_i) ? (last_i ? 2'b01 : 2'b10) : valid_i;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two requesters,
// one transaction in flight, round-robin grant, registered operands and result.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 3,
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_out
);
  state_e state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, rdy_q, rdy_d, zero_q, zero_d;
  logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d, data_q, data_d;
  logic [OP_W-1:0] ctrl_q, ctrl_d;
  logic [1:0] gnt;
  rr_arb2 u_arb (
    .valid_i({r1_valid, r0_valid}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: if (rdy_q && |gnt) begin
        owner_d = gnt[1];
        last_d  = gnt[1];
        ctrl_d  = gnt[1] ? r1_op : r0_op;
        in1_d   = gnt[1] ? r1_a : r0_a;
        in2_d   = gnt[1] ? r1_b : r0_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        data_d  = alu_out;
        zero_d  = (alu_out == '0);
        state_d = ST_RESP;
      end
      ST_RESP: state_d = (owner_q ? r1_rsp_ready : r0_rsp_ready) ? ST_IDLE : ST_RESP;
      default: state_d = ST_IDLE;
    endcase
    // Ready is registered, so it only rises on the cycle the FSM sits in IDLE.
    rdy_d = (state_d == ST_IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= !RESET_PRIO;
      rdy_q   <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end
  assign r0_ready     = rdy_q;
  assign r1_ready     = rdy_q;
  assign r0_rsp_valid = (state_q == ST_RESP) && !owner_q;
  assign r1_rsp_valid = (state_q == ST_RESP) && owner_q;
  assign rsp_data     = data_q;
  assign rsp_zero     = zero_q;
  assign alu_in1      = in1_q;
  assign alu_in2      = in2_q;
  assign alu_ctrl     = ctrl_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for the shared-ALU arbiter with a behavioural ALU.
module tb_alu_share_arbiter;
  import alu_pkg::*;
  localparam bit RP = 1'b0;
  logic clk = 0, rst_n;
  logic r0_valid, r0_ready, r1_valid, r1_ready;
  logic [2:0] r0_op, r1_op, alu_ctrl;
  logic [31:0] r0_a, r0_b, r1_a, r1_b, rsp_data, alu_in1, alu_in2, alu_out;
  logic r0_rsp_valid, r0_rsp_ready, r1_rsp_valid, r1_rsp_ready, rsp_zero;
  typedef struct packed {logic [2:0] op; logic [31:0] a, b, d;} req_t;
  typedef struct {bit id; logic [2:0] op; logic [31:0] a, b, d; logic z; int acc;} exp_t;
  req_t q0[$], q1[$];
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  bit ptr = !RP;
  alu_share_arbiter #(.DATA_W(32), .OP_W(3), .RESET_PRIO(RP)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_out(alu_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_out = alu_in1 + alu_in2;
      ALU_SUB: alu_out = alu_in1 - alu_in2;
      ALU_AND: alu_out = alu_in1 & alu_in2;
      ALU_OR:  alu_out = alu_in1 | alu_in2;
      ALU_SLT: alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
      ALU_XOR: alu_out = alu_in1 ^ alu_in2;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] d);
    req_t r;
    r = {op, a, b, d};
    if (id) q1.push_back(r);
    else q0.push_back(r);
  endtask
  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d requests still outstanding", sb.size() + q0.size() + q1.size());
    end
    @(negedge clk);
  endtask
  // Driver: presents queue heads; loser keeps its request until granted.
  initial begin
    r0_valid = 0; r1_valid = 0;
    r0_op = 0; r0_a = 0; r0_b = 0; r1_op = 0; r1_a = 0; r1_b = 0;
    forever begin
      @(posedge clk);
      #1;
      r0_valid = q0.size() != 0;
      r1_valid = q1.size() != 0;
      if (q0.size() != 0) {r0_op, r0_a, r0_b} = {q0[0].op, q0[0].a, q0[0].b};
      if (q1.size() != 0) {r1_op, r1_a, r1_b} = {q1[0].op, q1[0].a, q1[0].b};
    end
  end
  // Acceptance model: independent round-robin pointer decides who the DUT takes.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && r0_ready && (r0_valid || r1_valid)) begin
        bit w;
        req_t r;
        exp_t e;
        w = (r0_valid && r1_valid) ? !ptr : r1_valid;
        r = w ? q1.pop_front() : q0.pop_front();
        e.id = w; e.op = r.op; e.a = r.a; e.b = r.b; e.d = r.d; e.z = (r.d == 0); e.acc = cyc;
        sb.push_back(e);
        ptr = w;
      end
    end
  end
  // Monitor: checks latency/owner on first response cycle, data on handshake.
  initial begin
    bit seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 0;
      else if (r0_rsp_valid || r1_rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid r0=%b r1=%b with nothing outstanding", r0_rsp_valid, r1_rsp_valid);
        end else begin
          if (!seen) begin
            seen = 1;
            chk("latency", 32'(cyc - sb[0].acc), 32'd2);
            chk("rsp_owner", {31'b0, r1_rsp_valid}, {31'b0, sb[0].id});
            chk("rsp_onehot", {31'b0, r0_rsp_valid & r1_rsp_valid}, 32'd0);
            chk("alu_ctrl", {29'b0, alu_ctrl}, {29'b0, sb[0].op});
            chk("alu_in1", alu_in1, sb[0].a);
            chk("alu_in2", alu_in2, sb[0].b);
            chk("ready_in_resp", {30'b0, r1_ready, r0_ready}, 32'd0);
          end
          if ((r0_rsp_valid && r0_rsp_ready) || (r1_rsp_valid && r1_rsp_ready)) begin
            chk("rsp_data", rsp_data, sb[0].d);
            chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, sb[0].z});
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end
    end
  end
  initial begin
    int n;
    rst_n = 0; r0_rsp_ready = 1; r1_rsp_ready = 1;
    #12;
    chk("reset_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
    chk("reset_rsp_valid", {30'b0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", {30'b0, r1_ready, r0_ready}, 32'd3);
    // Tie right after reset: r0 first, then r1.
    push(0, ALU_SUB, 32'd9, 32'd9, 32'd0);
    push(1, ALU_OR, 32'hF0, 32'h0F, 32'hFF);
    drain();
    push(0, ALU_ADD, 32'd5, 32'd7, 32'd12);
    drain();
    push(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    drain();
    push(1, ALU_XOR, 32'h1234, 32'h1234, 32'd0);
    drain();
    // Continuous tie, last grant was r1: expect 0,1,0,1,0,1.
    push(0, ALU_ADD, 32'd1, 32'd2, 32'd3);
    push(0, ALU_AND, 32'hFF00, 32'h0FF0, 32'h0F00);
    push(0, 3'b111, 32'd1, 32'd1, 32'hDEAD_BEEF);
    push(1, ALU_SUB, 32'd10, 32'd3, 32'd7);
    push(1, ALU_XOR, 32'hAAAA, 32'h5555, 32'hFFFF);
    push(1, 3'b100, 32'd0, 32'd0, 32'hDEAD_BEEF);
    drain();
    // Backpressure on r0 while r1 offers rsp_ready.
    r0_rsp_ready = 0;
    push(0, ALU_ADD, 32'h100, 32'h23, 32'h123);
    n = 0;
    while (!r0_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", {31'b0, r0_rsp_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_data_stable", rsp_data, 32'h123);
      chk("bp_r1_rsp_valid", {31'b0, r1_rsp_valid}, 32'd0);
      chk("bp_ready_low", {30'b0, r1_ready, r0_ready}, 32'd0);
      chk("bp_r0_rsp_valid", {31'b0, r0_rsp_valid}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 r0_rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", {30'b0, r1_ready, r0_ready}, 32'd3);
    chk("bp_rsp_dropped", {31'b0, r0_rsp_valid}, 32'd0);
    chk("bp_data_retained", rsp_data, 32'h123);
    // Reset while the op is in EXEC.
    push(0, ALU_XOR, 32'd3, 32'd4, 32'd7);
    n = 0;
    while (!(sb.size() == 1 && !r0_ready && !r0_rsp_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("exec_reached", 32'(n < 20), 32'd1);
    chk("exec_alu_in1", alu_in1, 32'd3);
    #1 rst_n = 0;
    #1;
    chk("arst_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
    chk("arst_rsp_valid", {30'b0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
    chk("arst_rsp_data", rsp_data, 32'd0);
    chk("arst_alu_in1", alu_in1, 32'd0);
    chk("arst_alu_in2", alu_in2, 32'd0);
    chk("arst_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
    sb.delete();
    ptr = !RP;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_for_dropped", {30'b0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
    end
    chk("ready_after_arst", {30'b0, r1_ready, r0_ready}, 32'd3);
    push(1, ALU_ADD, 32'd3, 32'd3, 32'd6);
    push(0, ALU_ADD, 32'd2, 32'd2, 32'd4);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
